stream_to_1d_array_packer: RTL and testbench

//   Collects BIT_WIDTH-bit elements from a valid/ready stream, one per cycle, and

---
 rtl/stream_to_1d_array_packer.sv | 70 +++++++
 tb/tb_stream_to_1d_array_packer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_1d_array_packer.sv
// Packs BIT_WIDTH-bit stream elements into a COLS-wide word, column 0 at the LSBs,
// and holds the word on a valid/ready output until the consumer takes it.
module stream_to_1d_array_packer #(
  parameter int BIT_WIDTH = 4,
  parameter int COLS      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BIT_WIDTH-1:0]         in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [COLS*BIT_WIDTH-1:0]    out_data,
  output logic [$clog2(COLS+1)-1:0]    out_count,
  output logic                         out_valid,
  input  logic                         out_ready
);

  // state | meaning
  // FILL  | accepting elements into out_data, column idx is next to be written
  // HOLD  | word complete, presented on out_valid until out_ready

  localparam int IW = $clog2(COLS);
  localparam int CW = $clog2(COLS+1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state;
  logic [IW-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            out_data[idx*BIT_WIDTH +: BIT_WIDTH] <= in_data;
            if (idx == IW'(COLS-1) || in_last) begin
              state     <= HOLD;
              out_count <= CW'(idx) + CW'(1);
              idx       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
          // Clearing here keeps columns skipped by an early in_last at zero.
          if (out_ready) begin
            state     <= FILL;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_to_1d_array_packer.sv
// Randomized bench for stream_to_1d_array_packer with a queue-based reference model
// and a negedge monitor that scores every handshake and held word.
module tb_stream_to_1d_array_packer;

  localparam int BW   = 4;
  localparam int COLS = 8;
  localparam int CW   = $clog2(COLS+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [BW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [COLS*BW-1:0] out_data;
  logic [CW-1:0]     out_count;
  logic              out_valid;
  logic              out_ready = 1'b1;

  stream_to_1d_array_packer #(.BIT_WIDTH(BW), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [COLS*BW-1:0] d; int c; } word_t;

  int        vectors = 0;
  int        miscompares = 0;
  int        rdy_mode = 0;     // 0: always ready, 1: random, 2: stalled
  logic [BW-1:0] cur[$];       // elements of the word being filled
  word_t     exp_q[$];         // completed words awaiting drain
  bit        hold_exp = 1'b0;  // model: a word is being presented

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [COLS*BW-1:0] pack(input logic [BW-1:0] e[$]);
    logic [COLS*BW-1:0] w = '0;
    for (int i = 0; i < e.size(); i++)
      w = w | ({{(COLS*BW-BW){1'b0}}, e[i]} << (i*BW));
    return w;
  endfunction

  // Monitor/scoreboard: values seen at negedge are what the next posedge acts on.
  always @(negedge clk) begin
    if (rst) begin
      cur.delete();
      exp_q.delete();
      hold_exp = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!hold_exp));
      check("out_valid", 64'(out_valid), 64'(hold_exp));
      if (hold_exp) begin
        check("out_data", 64'(out_data), 64'(exp_q[0].d));
        check("out_count", 64'(out_count), 64'(exp_q[0].c));
        if (out_ready) begin
          void'(exp_q.pop_front());
          hold_exp = 1'b0;
        end
      end else begin
        check("fill_data", 64'(out_data), 64'(pack(cur)));
        if (in_valid) begin
          cur.push_back(in_data);
          if (cur.size() == COLS || in_last) begin
            word_t w;
            w.d = pack(cur);
            w.c = cur.size();
            exp_q.push_back(w);
            hold_exp = 1'b1;
            cur.delete();
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic push(input logic [BW-1:0] d, input logic last, input int gap_pct);
    bit acc;
    int guard = 0;
    while ($urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = BW'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_last = last;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      guard++;
      if (guard > 200) begin
        check("accept_timeout", 64'(guard), 64'(0));
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = BW'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic send_seq(input int n, input bit last_on_end, input int gap_pct);
    for (int i = 0; i < n; i++)
      push(BW'(i + 1), (i == n - 1) ? last_on_end : 1'b0, gap_pct);
  endtask

  task automatic wait_word(input string name, input logic [COLS*BW-1:0] d, input int c);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check({name, "_seen"}, 64'(out_valid), 64'(1));
    check({name, "_data"}, 64'(out_data), 64'(d));
    check({name, "_count"}, 64'(out_count), 64'(c));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_count", 64'(out_count), 64'(0));
    @(posedge clk); #1;

    // Full word back to back
    rdy_mode = 0;
    send_seq(8, 1'b0, 0);
    wait_word("full", 32'h87654321, 8);
    @(posedge clk); #1;

    // Early last
    push(4'hA, 1'b0, 0); push(4'hB, 1'b0, 0); push(4'hC, 1'b1, 0);
    wait_word("early", 32'h00000CBA, 3);
    @(posedge clk); #1;

    // Backpressure: held for 5 cycles, then drained
    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    send_seq(8, 1'b1, 0);
    wait_word("stall", 32'h87654321, 8);
    repeat (5) @(negedge clk);
    check("stall_valid", 64'(out_valid), 64'(1));
    rdy_mode = 0;
    repeat (4) @(posedge clk); #1;

    // Gapped input
    send_seq(8, 1'b0, 50);
    wait_word("gapped", 32'h87654321, 8);
    @(posedge clk); #1;

    // Reset mid-fill
    send_seq(3, 1'b0, 0);
    pulse_rst();
    send_seq(8, 1'b0, 0);
    wait_word("rst_fill", 32'h87654321, 8);
    @(posedge clk); #1;

    // Reset while holding
    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    send_seq(5, 1'b1, 0);
    wait_word("pre_rst_hold", 32'h00054321, 5);
    @(posedge clk); #1;
    pulse_rst();
    @(negedge clk);
    check("rsthold_valid", 64'(out_valid), 64'(0));
    check("rsthold_count", 64'(out_count), 64'(0));
    check("rsthold_data", 64'(out_data), 64'(0));
    check("rsthold_ready", 64'(in_ready), 64'(1));
    rdy_mode = 0;
    @(posedge clk); #1;

    // Randomized traffic
    rdy_mode = 1;
    for (int w = 0; w < 300; w++) begin
      int n = $urandom_range(1, COLS);
      for (int i = 0; i < n; i++)
        push(BW'($urandom), (i == n - 1) ? 1'($urandom_range(0, 3) != 0) : 1'b0,
             $urandom_range(0, 30));
    end

    rdy_mode = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
